// File: rtl/row_rw_bram.sv
// Word-serial row mover between the filter datapath and the BRAM controller.
// Gathers (read) or scatters (write) one row over the trig/done handshake, with per-word timeout.
module row_rw_bram #(
    parameter int DATA_W    = 32,
    parameter int WORDS     = 16,
    parameter int ROW_W     = 9,
    parameter int TIMEOUT   = 1024,
    localparam int WIDX_W   = $clog2(WORDS),
    localparam int ROW_BITS = DATA_W * WORDS
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_trig,
    input  logic                    i_mode,
    input  logic [ROW_W-1:0]        i_row_num,
    input  logic [ROW_BITS-1:0]     i_wr_row,
    output logic [ROW_BITS-1:0]     o_rd_row,
    output logic                    o_done,
    output logic                    o_err,
    output logic [ROW_W+WIDX_W-1:0] o_bram_addr,
    output logic                    o_bram_trig,
    output logic                    o_bram_we,
    output logic [DATA_W-1:0]       o_bram_wdata,
    input  logic [DATA_W-1:0]       i_bram_rdata,
    input  logic                    i_bram_done
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [WIDX_W-1:0] IDX_LAST = WIDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP,
        FIN
    } state_t;

    typedef logic [WORDS-1:0][DATA_W-1:0] row_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [ROW_W-1:0]    row_q, row_d;
    row_t                wr_row_q, wr_row_d;
    row_t                shadow_q, shadow_d;
    logic [ROW_BITS-1:0] rd_row_q, rd_row_d;
    logic [WIDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    // Word 0 is the MSB slice, so word k lives at packed element WORDS-1-k, i.e. ~k.
    always_comb begin
        // NOTE: every next-state value defaults to its register so no path infers a latch.
        state_d  = state_q;
        mode_d   = mode_q;
        row_d    = row_q;
        wr_row_d = wr_row_q;
        shadow_d = shadow_q;
        rd_row_d = rd_row_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (i_trig) begin
                    mode_d   = i_mode;
                    row_d    = i_row_num;
                    wr_row_d = i_wr_row;
                    idx_d    = '0;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (i_bram_done) begin
                    cnt_d = '0;
                    if (!mode_q) begin
                        shadow_d[~idx_q] = i_bram_rdata;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = FIN;
                        // Commit the whole row only once the final word has landed.
                        if (!mode_q) begin
                            rd_row_d = shadow_d;
                        end
                    end else begin
                        state_d = GAP;
                    end
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = FIN;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                idx_d   = idx_q + 1'b1;
                state_d = REQ;
            end
            FIN: begin
                if (!i_trig) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            row_q    <= '0;
            wr_row_q <= '0;
            rd_row_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            row_q    <= row_d;
            wr_row_q <= wr_row_d;
            rd_row_q <= rd_row_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // NOTE: the shadow row is left unreset; every word is rewritten before a read can commit it.
    always_ff @(posedge i_clk) begin
        shadow_q <= shadow_d;
    end

    assign o_bram_trig  = (state_q == REQ);
    assign o_done       = (state_q == FIN);
    assign o_err        = err_q;
    assign o_rd_row     = rd_row_q;
    assign o_bram_addr  = {row_q, idx_q};
    assign o_bram_we    = mode_q;
    assign o_bram_wdata = wr_row_q[~idx_q];

endmodule

// File: tb/tb_row_rw_bram.sv
// Directed bench for row_rw_bram: BRAM controller model with configurable latency,
// stall word and GAP-cycle noise pulse; checks addresses, data, latency and error paths.
module tb_row_rw_bram;

    localparam int DATA_W  = 32;
    localparam int WORDS   = 16;
    localparam int ROW_W   = 9;
    localparam int TIMEOUT = 8;
    localparam int RB      = DATA_W * WORDS;
    localparam int AW      = ROW_W + 4;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_trig;
    logic              i_mode;
    logic [ROW_W-1:0]  i_row_num;
    logic [RB-1:0]     i_wr_row;
    logic [RB-1:0]     o_rd_row;
    logic              o_done;
    logic              o_err;
    logic [AW-1:0]     o_bram_addr;
    logic              o_bram_trig;
    logic              o_bram_we;
    logic [DATA_W-1:0] o_bram_wdata;
    logic [DATA_W-1:0] i_bram_rdata = '0;
    logic              i_bram_done = 1'b0;

    row_rw_bram #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS),
        .ROW_W  (ROW_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_trig      (i_trig),
        .i_mode      (i_mode),
        .i_row_num   (i_row_num),
        .i_wr_row    (i_wr_row),
        .o_rd_row    (o_rd_row),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_bram_addr (o_bram_addr),
        .o_bram_trig (o_bram_trig),
        .o_bram_we   (o_bram_we),
        .o_bram_wdata(o_bram_wdata),
        .i_bram_rdata(i_bram_rdata),
        .i_bram_done (i_bram_done)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Controller model state
    int          resp_d       = 2;
    logic [31:0] data_base    = 32'hA000_0000;
    bit          stall_en     = 1'b0;
    int          stall_word   = 0;
    bit          gap_pulse_en = 1'b0;
    int          req_cnt      = 0;
    int          last_req_len = 0;
    logic [AW-1:0]     log_addr[$];
    logic              log_we[$];
    logic [DATA_W-1:0] log_wdata[$];

    // Answers each request resp_d cycles after trig rises; logs every new request.
    always @(negedge i_clk) begin
        if (o_bram_trig) begin
            if (req_cnt == 0) begin
                log_addr.push_back(o_bram_addr);
                log_we.push_back(o_bram_we);
                log_wdata.push_back(o_bram_wdata);
            end
            req_cnt = req_cnt + 1;
            if (req_cnt == resp_d && !(stall_en && int'(o_bram_addr[3:0]) == stall_word)) begin
                i_bram_done  = 1'b1;
                i_bram_rdata = data_base + 32'(o_bram_addr[3:0]);
            end else begin
                i_bram_done  = 1'b0;
                i_bram_rdata = '0;
            end
        end else begin
            if (req_cnt != 0) last_req_len = req_cnt;
            req_cnt      = 0;
            i_bram_done  = gap_pulse_en;
            i_bram_rdata = gap_pulse_en ? 32'hDEAD_BEEF : 32'h0;
        end
    end

    int n_pass  = 0;
    int n_total = 0;
    int mutate_at = -1;

    task automatic check(input string tag, input logic [RB-1:0] obs, input logic [RB-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [RB-1:0] seq_row(input logic [31:0] base);
        logic [RB-1:0] r;
        r = '0;
        for (int k = 0; k < WORDS; k++) r[RB-1-k*DATA_W -: DATA_W] = base + 32'(k);
        return r;
    endfunction

    function automatic logic [AW-1:0] log_a(input int k);
        return (k < log_addr.size()) ? log_addr[k] : '1;
    endfunction

    task automatic clear_logs();
        log_addr.delete();
        log_we.delete();
        log_wdata.delete();
    endtask

    task automatic start_xfer(input logic mode, input logic [ROW_W-1:0] row, input logic [RB-1:0] wr);
        @(negedge i_clk);
        clear_logs();
        i_mode    = mode;
        i_row_num = row;
        i_wr_row  = wr;
        i_trig    = 1'b1;
    endtask

    // Waits for o_done (bounded), returns cycles from first o_bram_trig; ends one cycle into FIN.
    task automatic wait_done(output int lat);
        int first;
        first = -1;
        lat   = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge i_clk);
            if (i == mutate_at) begin
                i_row_num = 9'h0AA;
                i_mode    = 1'b1;
                i_wr_row  = '1;
            end
            if (o_bram_trig && first < 0) first = cyc;
            if (o_done) begin
                lat = cyc - first;
                break;
            end
        end
        check("done_seen", o_done, 1);
        @(negedge i_clk);
    endtask

    task automatic end_xfer();
        i_trig = 1'b0;
        @(negedge i_clk);
        check("done_cleared", o_done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int lat;
    logic [RB-1:0] row5;

    initial begin
        i_rst     = 1'b1;
        i_trig    = 1'b0;
        i_mode    = 1'b0;
        i_row_num = '0;
        i_wr_row  = '0;
        repeat (3) @(negedge i_clk);
        check("rst_done",  o_done, 0);
        check("rst_err",   o_err, 0);
        check("rst_trig",  o_bram_trig, 0);
        check("rst_addr",  o_bram_addr, 0);
        check("rst_we",    o_bram_we, 0);
        check("rst_wdata", o_bram_wdata, 0);
        check("rst_rdrow", o_rd_row, 0);
        i_rst = 1'b0;

        // Read row 5, D=2
        row5      = seq_row(32'hA000_0000);
        resp_d    = 2;
        data_base = 32'hA000_0000;
        start_xfer(1'b0, 9'd5, '0);
        wait_done(lat);
        check("rd5_latency", lat, 47);
        check("rd5_err", o_err, 0);
        check("rd5_row", o_rd_row, row5);
        check("rd5_nacc", log_addr.size(), 16);
        for (int k = 0; k < WORDS; k++) check($sformatf("rd5_addr%0d", k), log_a(k), {9'd5, 4'(k)});
        @(negedge i_clk);
        check("rd5_done_held", o_done, 1);
        end_xfer();

        // Write row 511, word k = k, D=1
        resp_d = 1;
        start_xfer(1'b1, 9'd511, seq_row(32'h0));
        wait_done(lat);
        check("wr_latency", lat, 31);
        check("wr_err", o_err, 0);
        check("wr_rdrow_kept", o_rd_row, row5);
        check("wr_nacc", log_addr.size(), 16);
        for (int k = 0; k < WORDS && k < log_addr.size(); k++) begin
            check($sformatf("wr_addr%0d", k), log_addr[k], {9'd511, 4'(k)});
            check($sformatf("wr_we%0d", k), log_we[k], 1);
            check($sformatf("wr_wdata%0d", k), log_wdata[k], k);
        end
        end_xfer();

        // Timeout on word 3
        resp_d     = 2;
        data_base  = 32'hC000_0000;
        stall_en   = 1'b1;
        stall_word = 3;
        start_xfer(1'b0, 9'd2, '0);
        wait_done(lat);
        check("to_latency", lat, 17);
        check("to_err", o_err, 1);
        check("to_done", o_done, 1);
        check("to_nacc", log_addr.size(), 4);
        check("to_last_addr", log_a(3), {9'd2, 4'd3});
        check("to_req_len", last_req_len, 8);
        check("to_rdrow_kept", o_rd_row, row5);
        end_xfer();
        check("to_err_holds", o_err, 1);
        stall_en = 1'b0;

        // Boundary: done arrives in the same cycle the timeout would fire
        resp_d    = 8;
        data_base = 32'hF000_0000;
        start_xfer(1'b0, 9'd8, '0);
        wait_done(lat);
        check("tie_latency", lat, 143);
        check("tie_err", o_err, 0);
        check("tie_row", o_rd_row, seq_row(32'hF000_0000));
        end_xfer();

        // Reset during word 7 of a read
        resp_d    = 2;
        data_base = 32'h3300_0000;
        start_xfer(1'b0, 9'd3, '0);
        for (int i = 0; i < 200; i++) begin
            @(negedge i_clk);
            if (o_bram_trig && o_bram_addr[3:0] == 4'd7) break;
        end
        check("mid_at_word7", o_bram_addr, {9'd3, 4'd7});
        i_rst  = 1'b1;
        i_trig = 1'b0;
        @(negedge i_clk);
        check("mr_trig",  o_bram_trig, 0);
        check("mr_done",  o_done, 0);
        check("mr_err",   o_err, 0);
        check("mr_addr",  o_bram_addr, 0);
        check("mr_we",    o_bram_we, 0);
        check("mr_wdata", o_bram_wdata, 0);
        check("mr_rdrow", o_rd_row, 0);
        i_rst = 1'b0;
        repeat (5) @(negedge i_clk);
        check("mr_no_more_acc", log_addr.size(), 8);
        data_base = 32'hB000_0000;
        start_xfer(1'b0, 9'd1, '0);
        wait_done(lat);
        check("r1_latency", lat, 47);
        check("r1_err", o_err, 0);
        check("r1_row", o_rd_row, seq_row(32'hB000_0000));
        check("r1_first_addr", log_a(0), {9'd1, 4'd0});

        // Back-to-back: trig held, dropped for one cycle, raised with a new row
        @(negedge i_clk);
        check("b2b_done_held", o_done, 1);
        i_trig = 1'b0;
        @(negedge i_clk);
        check("b2b_idle", o_done, 0);
        clear_logs();
        data_base = 32'hD000_0000;
        i_row_num = 9'd6;
        i_trig    = 1'b1;
        @(negedge i_clk);
        check("b2b_restart_trig", o_bram_trig, 1);
        check("b2b_restart_addr", o_bram_addr, {9'd6, 4'd0});
        wait_done(lat);
        check("b2b_row", o_rd_row, seq_row(32'hD000_0000));
        end_xfer();

        // Inputs changed mid-transfer and done pulsed during every GAP
        data_base    = 32'hE000_0000;
        gap_pulse_en = 1'b1;
        mutate_at    = 10;
        start_xfer(1'b0, 9'd7, '0);
        wait_done(lat);
        mutate_at    = -1;
        gap_pulse_en = 1'b0;
        check("mut_latency", lat, 47);
        check("mut_row", o_rd_row, seq_row(32'hE000_0000));
        check("mut_nacc", log_addr.size(), 16);
        for (int k = 0; k < WORDS && k < log_addr.size(); k++) begin
            check($sformatf("mut_addr%0d", k), log_addr[k], {9'd7, 4'(k)});
            check($sformatf("mut_we%0d", k), log_we[k], 0);
        end
        end_xfer();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
